// File: rtl/pipe_muldiv.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake and flush.
// A shared 2*XLEN accumulator serves both shift-add multiply and restoring divide.
module pipe_muldiv #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned N    = XLEN / UNROLL;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                neg_q, neg_d;
  logic                special_q, special_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [TAG_W-1:0]    tag_out_q, tag_out_d;

  logic                a_signed, b_signed, a_neg, b_neg, is_special;
  logic [XLEN-1:0]     a_mag, b_mag, special_val;
  logic [2*XLEN-1:0]   step_acc, prod;
  logic [XLEN:0]       sum, rext;
  logic [XLEN-1:0]     quo_rem, fix_val;

  // Operand decode: signedness, magnitudes and the CALC-bypassing special cases
  always_comb begin
    a_signed   = (op == 3'd1) || (op == 3'd2) || (op[2] && !op[0]);
    b_signed   = (op == 3'd1) || (op[2] && !op[0]);
    a_neg      = a_signed && a[XLEN-1];
    b_neg      = b_signed && b[XLEN-1];
    a_mag      = a_neg ? -a : a;
    b_mag      = b_neg ? -b : b;
    is_special = op[2] && ((b == '0) || (!op[0] && (a == MinNeg) && (b == '1)));
    // op[1] selects remainder; divide-by-zero and signed overflow differ only in that choice
    if (b == '0) special_val = op[1] ? a : '1;
    else         special_val = op[1] ? '0 : a;
  end

  // One CALC cycle: UNROLL shift-add (multiply) or restoring-subtract (divide) steps
  always_comb begin
    step_acc = acc_q;
    sum      = '0;
    rext     = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        // Partial remainder needs one extra bit after the left shift
        rext     = {step_acc[2*XLEN-1:XLEN], step_acc[XLEN-1]};
        step_acc = {step_acc[2*XLEN-2:0], 1'b0};
        if (rext >= {1'b0, opb_q}) begin
          sum                        = rext - {1'b0, opb_q};
          step_acc[2*XLEN-1:XLEN]    = sum[XLEN-1:0];
          step_acc[0]                = 1'b1;
        end else begin
          step_acc[2*XLEN-1:XLEN]    = rext[XLEN-1:0];
        end
      end else begin
        sum      = {1'b0, step_acc[2*XLEN-1:XLEN]} + (step_acc[0] ? {1'b0, opb_q} : '0);
        step_acc = {sum, step_acc[XLEN-1:1]};
      end
    end
  end

  // FIX stage: apply the recorded sign and pick the requested half / quotient / remainder
  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    quo_rem = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (special_q)         fix_val = acc_q[XLEN-1:0];
    else if (op_q[2])      fix_val = neg_q ? -quo_rem : quo_rem;
    else if (op_q == 3'd0) fix_val = prod[XLEN-1:0];
    else                   fix_val = prod[2*XLEN-1:XLEN];
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    neg_d     = neg_q;
    special_d = special_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    tag_out_d = tag_out_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d   = is_special ? StFix : StCalc;
            op_d      = op;
            tag_d     = tag_in;
            // Remainder takes the dividend's sign; everything else the product/quotient sign
            neg_d     = (op == 3'd6) ? a_neg : (a_neg ^ b_neg);
            special_d = is_special;
            acc_d     = {{XLEN{1'b0}}, is_special ? special_val : a_mag};
            opb_d     = b_mag;
            cnt_d     = '0;
          end else begin
            state_d = StIdle;
          end
        end
        StCalc: begin
          acc_d = step_acc;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(N - 1)) state_d = StFix;
        end
        StFix: begin
          state_d   = StDone;
          result_d  = fix_val;
          tag_out_d = tag_q;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      tag_q     <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      acc_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      tag_out_q <= tag_out_d;
    end
  end

  assign busy    = (state_q == StCalc) || (state_q == StFix);
  assign done    = (state_q == StDone);
  assign result  = result_q;
  assign tag_out = tag_out_q;

endmodule

// File: tb/tb_pipe_muldiv.sv
// Bench for pipe_muldiv: three instances (UNROLL 1, 2, 4) share one random stimulus stream
// and are checked every cycle against an arithmetic reference and a cycle-expectation table.
module tb_pipe_muldiv;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  tag_in = '0;

  logic        busy_w [NI];
  logic        done_w [NI];
  logic [31:0] res_w  [NI];
  logic [4:0]  tag_w  [NI];

  pipe_muldiv #(.XLEN(32), .UNROLL(1), .TAG_W(5)) u_dut_u1 (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op), .a(a), .b(b),
    .tag_in(tag_in), .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0]), .tag_out(tag_w[0])
  );
  pipe_muldiv #(.XLEN(32), .UNROLL(2), .TAG_W(5)) u_dut_u2 (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op), .a(a), .b(b),
    .tag_in(tag_in), .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1]), .tag_out(tag_w[1])
  );
  pipe_muldiv #(.XLEN(32), .UNROLL(4), .TAG_W(5)) u_dut_u4 (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op), .a(a), .b(b),
    .tag_in(tag_in), .busy(busy_w[2]), .done(done_w[2]), .result(res_w[2]), .tag_out(tag_w[2])
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Expected-behaviour table per instance (absolute cycle numbers)
  int          exp_done [NI];
  int          busy_lo  [NI];
  int          busy_hi  [NI];
  logic [31:0] pend_res [NI];
  logic [31:0] vis_res  [NI];
  logic [4:0]  pend_tag [NI];
  logic [4:0]  vis_tag  [NI];

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, got, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return 32 / (1 << i) + 2;
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    return (f3 >= 3'd4) && ((y == 32'd0) ||
           (((f3 == 3'd4) || (f3 == 3'd6)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)));
  endfunction

  // Reference RV32M semantics using 64-bit arithmetic and the language's signed / and %
  function automatic logic [31:0] ref_muldiv(input logic [2:0] f3, input logic [31:0] x,
                                             input logic [31:0] y);
    logic [63:0] sx, zx, sy, zy, p;
    sx = {{32{x[31]}}, x};
    zx = {32'd0, x};
    sy = {{32{y[31]}}, y};
    zy = {32'd0, y};
    case (f3)
      3'd0: begin p = zx * zy; return p[31:0];  end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * zy; return p[63:32]; end
      3'd3: begin p = zx * zy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return $signed(x) / $signed(y);
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return $signed(x) % $signed(y);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Advance to the middle of the next cycle and check every instance against the table
  task automatic tick();
    logic eb, ed;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (cyc == exp_done[i]) begin
        vis_res[i] = pend_res[i];
        vis_tag[i] = pend_tag[i];
      end
      eb = (cyc >= busy_lo[i]) && (cyc <= busy_hi[i]);
      ed = (cyc == exp_done[i]);
      check_eq($sformatf("u%0d_busy@%0d", 1 << i, cyc), 32'(busy_w[i]), 32'(eb));
      check_eq($sformatf("u%0d_done@%0d", 1 << i, cyc), 32'(done_w[i]), 32'(ed));
      check_eq($sformatf("u%0d_result@%0d", 1 << i, cyc), res_w[i], vis_res[i]);
      check_eq($sformatf("u%0d_tag@%0d", 1 << i, cyc), 32'(tag_w[i]), 32'(vis_tag[i]));
    end
  endtask

  function automatic bit all_ready();
    for (int i = 0; i < NI; i++) if (cyc <= busy_hi[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Ends in the first cycle where every instance can accept (the DONE cycle of the slowest)
  task automatic wait_ready();
    int n = 0;
    while (!all_ready() && n < 60) begin
      tick();
      n++;
    end
    if (!all_ready()) check_eq("ready_bound", 32'(all_ready()), 32'd1);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] t);
    bit sp;
    wait_ready();
    op = f3; a = x; b = y; tag_in = t; start = 1'b1;
    sp = is_special(f3, x, y);
    for (int i = 0; i < NI; i++) begin
      busy_lo[i]  = cyc + 1;
      busy_hi[i]  = sp ? cyc + 1 : cyc + lat_of(i) - 1;
      exp_done[i] = sp ? cyc + 2 : cyc + lat_of(i);
      pend_res[i] = ref_muldiv(f3, x, y);
      pend_tag[i] = t;
    end
    tick();
    // Operands are don't-care after the accepting edge
    start = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom; tag_in = 5'($urandom);
  endtask

  task automatic do_flush(input bit with_start);
    flush = 1'b1;
    if (with_start) begin
      start = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom; tag_in = 5'($urandom);
    end
    for (int i = 0; i < NI; i++) begin
      if (exp_done[i] > cyc) begin
        busy_hi[i]  = cyc;
        exp_done[i] = -1;
      end
    end
    tick();
    flush = 1'b0;
    start = 1'b0;
  endtask

  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("u%0d_rst_busy", 1 << i), 32'(busy_w[i]), 32'd0);
      check_eq($sformatf("u%0d_rst_done", 1 << i), 32'(done_w[i]), 32'd0);
      check_eq($sformatf("u%0d_rst_result", 1 << i), res_w[i], 32'd0);
      check_eq($sformatf("u%0d_rst_tag", 1 << i), 32'(tag_w[i]), 32'd0);
      exp_done[i] = -1;
      busy_hi[i]  = -1;
      vis_res[i]  = '0;
      vis_tag[i]  = '0;
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct { logic [2:0] f3; logic [31:0] x; logic [31:0] y; } vec_t;
  vec_t dir [10];

  initial begin
    for (int i = 0; i < NI; i++) begin
      exp_done[i] = -1; busy_lo[i] = 0; busy_hi[i] = -1;
      pend_res[i] = '0; vis_res[i] = '0; pend_tag[i] = '0; vis_tag[i] = '0;
    end
    dir[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3};
    dir[1] = '{3'd0, 32'hFFFF_FFFE, 32'd3};
    dir[2] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    dir[3] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    dir[4] = '{3'd4, 32'd7, 32'hFFFF_FFFE};
    dir[5] = '{3'd6, 32'd7, 32'hFFFF_FFFE};
    dir[6] = '{3'd5, 32'd7, 32'd2};
    dir[7] = '{3'd7, 32'd7, 32'd2};
    dir[8] = '{3'd5, 32'h1234_5678, 32'd0};
    dir[9] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF};

    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed operations, each followed by idle gaps
    foreach (dir[k]) begin
      issue(dir[k].f3, dir[k].x, dir[k].y, 5'($urandom));
      wait_ready();
      tick();
    end

    // Flush in cycle 10 of a DIV, then start together with flush from idle
    issue(3'd4, 32'hDEAD_BEEF, 32'd13, 5'd9);
    repeat (9) tick();
    do_flush(1'b0);
    wait_ready();
    tick();
    do_flush(1'b1);
    tick();

    // Back-to-back: second start lands in the DONE cycle of the slowest instance
    issue(3'd1, 32'h8765_4321, 32'h0FED_CBA9, 5'd3);
    issue(3'd7, 32'h0000_FFFF, 32'd0, 5'd4);
    issue(3'd6, 32'hFFFF_FF00, 32'd7, 5'd5);
    wait_ready();

    // Asynchronous reset in the middle of CALC
    issue(3'd3, 32'hCAFE_F00D, 32'h1357_9BDF, 5'd17);
    repeat (4) tick();
    reset_mid();
    repeat (3) tick();

    // Random operations with biased special cases and random idle gaps
    for (int k = 0; k < 30; k++) begin
      logic [2:0]  f3;
      logic [31:0] x, y;
      int unsigned r;
      f3 = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = $urandom;
      r  = $urandom_range(0, 15);
      if (r == 0) y = 32'd0;
      if (r == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      if (r == 2) y = 32'($urandom_range(1, 7));
      if (r == 3) x = 32'($urandom_range(0, 100));
      issue(f3, x, y, 5'($urandom));
      wait_ready();
      repeat ($urandom_range(0, 2)) tick();
    end

    wait_ready();
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
